// File: rtl/rr_mux_arbiter_04.sv
// rr_mux_arbiter_04
// Four-way round-robin arbiter with a registered output mux. The block captures
// the winning requester's data word into a single output register and holds it
// until the sink accepts it. On an accepting cycle it can capture the next
// winner in the same cycle, so the output can carry one word per clock.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset
//   req    : request vector (bit0=a, bit1=b, bit2=c, bit3=d)
//   a..d   : requester data words, WIDTH bits each
//   ready  : sink accepts out when valid is high
//   out    : registered data word of the granted requester
//   valid  : out holds a word that has not been accepted yet
//   sel    : index of the current or last granted requester
//   gnt    : one-hot pulse, high for one cycle after each capture
//
// state | meaning
// IDLE  | no word held; valid=0; waiting for an eligible request
// BUSY  | word held in out; valid=1; waiting for ready
module rr_mux_arbiter_04 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [1:0]       sel,
  output logic [3:0]       gnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [3:0]       elig;
  logic [1:0]       base;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic             found;
  logic [WIDTH-1:0] win_word;

  // Masking with gnt stops a requester from being captured a second time
  // in the cycle where it sees its grant and has not yet dropped req.
  // On an accepting BUSY cycle, last is about to become sel, so the search
  // starts from sel to arbitrate from the updated pointer.
  always_comb begin
    elig  = req & ~gnt;
    base  = (state == BUSY) ? sel : last;
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_word = a;
      2'd1:    win_word = b;
      2'd2:    win_word = c;
      default: win_word = d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 2'd3;
      out   <= '0;
      valid <= 1'b0;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
    end else begin
      gnt <= 4'b0000;
      case (state)
        IDLE: begin
          if (found) begin
            out   <= win_word;
            sel   <= win;
            gnt   <= 4'b0001 << win;
            valid <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ready) begin
            last <= sel;
            if (found) begin
              out   <= win_word;
              sel   <= win;
              gnt   <= 4'b0001 << win;
              valid <= 1'b1;
              state <= BUSY;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_04.sv
module tb_rr_mux_arbiter_04;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] a, b, c, d;
  logic             ready;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic [1:0]       sel;
  logic [3:0]       gnt;

  rr_mux_arbiter_04 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .ready(ready), .out(out), .valid(valid), .sel(sel), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic [1:0]       sel;
    logic             valid;
    logic [3:0]       gnt;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // reference state, updated once per clock edge
  logic [WIDTH-1:0] m_out;
  logic [1:0]       m_sel;
  logic [1:0]       m_last;
  logic             m_valid;
  logic [3:0]       m_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_sel = 2'd0; m_last = 2'd3; m_valid = 1'b0; m_gnt = 4'b0000;
  endtask

  function automatic logic [WIDTH-1:0] word_of(input logic [1:0] i);
    case (i)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  // Advance the reference by one edge using the currently driven inputs.
  task automatic model_edge();
    logic [3:0] el;
    logic [1:0] start;
    logic [1:0] cand;
    logic       take;
    bit         hit;
    el   = req & ~m_gnt;
    take = 1'b0;
    start = m_last;
    if (!m_valid) begin
      take = (el != 4'b0000);
    end else if (ready) begin
      m_last = m_sel;
      start  = m_sel;
      take   = (el != 4'b0000);
      if (!take) m_valid = 1'b0;
    end
    m_gnt = 4'b0000;
    if (take) begin
      hit = 0;
      for (int k = 1; k <= 4; k++) begin
        cand = start + 2'(k);
        if (!hit && el[cand]) begin
          hit     = 1;
          m_sel   = cand;
          m_out   = word_of(cand);
          m_gnt   = 4'b0001 << cand;
          m_valid = 1'b1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, push the expected result, compare after the edge.
  task automatic step(input logic [3:0] r, input logic rd);
    exp_t e;
    req   = r;
    ready = rd;
    model_edge();
    e.out = m_out; e.sel = m_sel; e.valid = m_valid; e.gnt = m_gnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("out",   32'(out),   32'(e.out));
    chk("sel",   32'(sel),   32'(e.sel));
    chk("valid", 32'(valid), 32'(e.valid));
    chk("gnt",   32'(gnt),   32'(e.gnt));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out"},   32'(out),   32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_gnt"},   32'(gnt),   32'd0);
    chk({tag, "_sel"},   32'(sel),   32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [1:0]       exp_seq [5];
  logic [WIDTH-1:0] exp_word[5];

  initial begin
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    a = 4'b0001; b = 4'b0010; c = 4'b0100; d = 4'b1000;
    model_reset();
    #1;
    check_reset_vals("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // single requester A, masked re-capture, then recaptured
    step(4'b0001, 1'b1);
    chk("s26_out", 32'(out), 32'h1);
    chk("s26_gnt", 32'(gnt), 32'h1);
    step(4'b0001, 1'b1);
    chk("s26_idle", 32'(valid), 32'd0);
    step(4'b0001, 1'b1);
    chk("s26_again", 32'(gnt), 32'h1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // all requesting, back-to-back rotation
    do_reset();
    exp_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_word = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      chk("s27_sel",   32'(sel),   32'(exp_seq[i]));
      chk("s27_out",   32'(out),   32'(exp_word[i]));
      chk("s27_valid", 32'(valid), 32'd1);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // stall with changing data
    do_reset();
    step(4'b0001, 1'b0);
    chk("s28_cap", 32'(out), 32'h1);
    a = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      chk("s28_hold_out", 32'(out), 32'h1);
      chk("s28_hold_gnt", 32'(gnt), 32'h0);
    end
    step(4'b0000, 1'b1);
    chk("s28_done", 32'(valid), 32'd0);
    a = 4'b0001;

    // pointer after C: A wins, then C
    do_reset();
    step(4'b0100, 1'b1);
    chk("s29_c", 32'(sel), 32'd2);
    step(4'b0000, 1'b1);
    step(4'b0101, 1'b0);
    chk("s29_a", 32'(sel), 32'd0);
    step(4'b0101, 1'b1);
    chk("s29_c2", 32'(sel), 32'd2);
    step(4'b0000, 1'b1);

    // reset mid-BUSY between edges
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("s30");
    model_reset();
    #1;
    rst = 1'b0;
    step(4'b1111, 1'b1);
    chk("s30_first", 32'(gnt), 32'h1);
    step(4'b0000, 1'b1);

    // random traffic against the reference
    for (int i = 0; i < 300; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      c = WIDTH'($urandom); d = WIDTH'($urandom);
      step(4'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter_04.md
RR_MUX_ARBITER_04 -- requirements
Module: rr_mux_arbiter_04

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each requester and of OUT.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ  input  4  request vector; bit 0 = A, bit 1 = B, bit 2 = C, bit 3 = D.
REQ-005 A, B, C, D  input  WIDTH each  requester data words.
REQ-006 READY  input  1  sink ready to accept OUT.
REQ-007 OUT  output  WIDTH  registered data word of the granted requester.
REQ-008 VALID  output  1  OUT holds an unaccepted word.
REQ-009 SEL  output  2  registered index of the current/last granted requester (00=A … 11=D).
REQ-010 GNT  output  4  one-hot, one-cycle pulse to the requester whose data was captured.

Function
REQ-011 The block SHALL implement two states: IDLE (VALID=0) and BUSY (VALID=1).
REQ-012 Arbitration SHALL be round-robin: search order starts at (LAST+1) mod 4 and wraps; LAST is the index of the most recently accepted transfer.
REQ-013 Eligible requests SHALL be REQ & ~GNT, so a requester is never captured twice off one REQ assertion.
REQ-014 In IDLE with any eligible request at an edge: capture the winner's data into OUT, set SEL to its index, pulse its GNT bit, set VALID=1, go BUSY. Latency is one edge from REQ to VALID.
REQ-015 In IDLE with no eligible request: OUT, SEL and LAST SHALL hold, VALID=0, GNT=0.
REQ-016 In BUSY with READY=0: OUT, SEL and VALID SHALL hold. GNT SHALL be 0 after its single pulse cycle. Changes on A–D or REQ SHALL NOT affect OUT.
REQ-017 In BUSY, an edge with VALID=1 and READY=1 completes the transfer: LAST<=SEL.
REQ-018 On completion, if an eligible request exists, the same edge SHALL capture the next winner (arbitrated from the updated LAST): back-to-back, VALID stays 1, one word per cycle. Otherwise go IDLE with VALID=0.
REQ-019 At most one GNT bit SHALL be high in any cycle, and GNT SHALL be high only in the cycle right after a capture edge.
REQ-020 Requesters SHALL hold REQ and data valid until their GNT pulse. REQ deasserted before capture SHALL withdraw the request; deassertion after GNT SHALL have no effect.
REQ-021 Simultaneous requests SHALL be resolved by REQ-012 alone. A requester with REQ held continuously SHALL be served within 4 transfers.
REQ-022 Registered SEL and OUT SHALL be consistent: OUT equals the word of requester SEL as sampled at the capture edge.

Reset
REQ-023 While RST=1, without waiting for a clock edge: OUT=0, VALID=0, GNT=0000, SEL=00, state=IDLE, LAST=3.
REQ-024 After reset, the first arbitration SHALL therefore start at A.
REQ-025 RST asserted mid-BUSY SHALL discard the pending word. No transfer completes and LAST is reinitialised.

Verification
REQ-026 Stimulus: reset; A=0001 B=0010 C=0100 D=1000; REQ=0001, READY=1. Required: after 1 edge OUT=0001, SEL=00, VALID=1, GNT=0001 for one cycle. Next edge: transfer completes, VALID=0 (A masked). Following edge: A re-captured.
REQ-027 Stimulus: REQ=1111 held, READY=1. Required: SEL sequence 00,01,10,11,00 on consecutive edges; OUT 0001,0010,0100,1000,0001; VALID continuously 1; GNT 0001,0010,0100,1000.
REQ-028 Stimulus: capture A (OUT=0001), then READY=0 for 3 cycles while A changes to 1111. Required: OUT=0001, VALID=1, SEL=00 stable, GNT=0000 after the first cycle. Transfer completes on the edge READY returns to 1.
REQ-029 Stimulus: after a completed C transfer (LAST=2), REQ=0101. Required: A granted first (SEL=00), then C (SEL=10).
REQ-030 Stimulus: RST pulsed between edges during BUSY. Required: OUT=0, VALID=0, GNT=0, SEL=00 immediately. After release with REQ=1111, the first grant goes to A.
